// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ valid/ready requesters.
// Grants bursts of up to MAX_BURST beats and drives wr_en/data_in from registers.
//
// state | meaning
// IDLE  | no owner; each cycle with space, grant the first valid requester from rr_ptr
// OWN   | owner holds the port until MAX_BURST beats are taken or it drops valid
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_overflow,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          overflow_err,
    output logic [CNT_WIDTH-1:0]          beat_count
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int BC_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [ID_W-1:0]   owner, owner_nxt;
    logic [BC_W-1:0]   burst_cnt, burst_nxt;

    logic              space;
    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    int                scan_pos;
    logic              accept;
    logic [ID_W-1:0]   acc_idx;

    logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
        logic [ID_W-1:0] nxt;
        if (int'(idx) == NUM_REQ - 1) begin
            nxt = '0;
        end else begin
            nxt = idx + 1'b1;
        end
        return nxt;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_word[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // A write already in flight may take the last slot, so almost-full blocks a
    // back-to-back beat; concurrent reads are ignored to stay on the safe side.
    assign space = !fifo_full && !(fifo_wr_en && fifo_almostfull);

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_pos  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_pos = int'(rr_ptr) + k;
            if (scan_pos >= NUM_REQ) begin
                scan_pos = scan_pos - NUM_REQ;
            end
            if (!win_found && req_valid[scan_pos]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(scan_pos);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        burst_nxt  = burst_cnt;
        req_ready  = '0;
        accept     = 1'b0;
        acc_idx    = owner;

        case (state)
            IDLE: begin
                if (space && win_found) begin
                    req_ready[win_idx] = 1'b1;
                    accept             = 1'b1;
                    acc_idx            = win_idx;
                    if (MAX_BURST == 1) begin
                        rr_ptr_nxt = next_idx(win_idx);
                    end else begin
                        owner_nxt = win_idx;
                        burst_nxt = BC_W'(1);
                        state_nxt = OWN;
                    end
                end
            end
            OWN: begin
                if (!req_valid[owner]) begin
                    // Re-arbitrate next cycle; this costs one bubble.
                    state_nxt  = IDLE;
                    rr_ptr_nxt = next_idx(owner);
                    burst_nxt  = '0;
                end else if (space) begin
                    req_ready[owner] = 1'b1;
                    accept           = 1'b1;
                    acc_idx          = owner;
                    burst_nxt        = burst_cnt + 1'b1;
                    if (burst_cnt + 1'b1 == BC_W'(MAX_BURST)) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = next_idx(owner);
                        burst_nxt  = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            burst_cnt    <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
            grant_id     <= '0;
            overflow_err <= 1'b0;
            beat_count   <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            owner      <= owner_nxt;
            burst_cnt  <= burst_nxt;
            fifo_wr_en <= accept;
            if (accept) begin
                fifo_data_in <= req_word[acc_idx];
                grant_id     <= acc_idx;
                beat_count   <= beat_count + 1'b1;
            end
            if (fifo_overflow) begin
                overflow_err <= 1'b1;
            end
        end
    end

    assign busy = (state == OWN);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: requester sources feed beats, expected
// writes are queued per scenario and compared as the FIFO write port emits them.
module tb_fifo_wr_arbiter;

    localparam int NR   = 4;
    localparam int DW   = 16;
    localparam int MB   = 4;
    localparam int CW   = 16;
    localparam int MAXB = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              fifo_full;
    logic              fifo_almostfull;
    logic              fifo_overflow;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_data_in;
    logic [1:0]        grant_id;
    logic              busy;
    logic              overflow_err;
    logic [CW-1:0]     beat_count;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB),
        .CNT_WIDTH (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .fifo_full      (fifo_full),
        .fifo_almostfull(fifo_almostfull),
        .fifo_overflow  (fifo_overflow),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_data_in   (fifo_data_in),
        .grant_id       (grant_id),
        .busy           (busy),
        .overflow_err   (overflow_err),
        .beat_count     (beat_count)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] src_data [NR][MAXB];
    int            src_head [NR];
    int            src_len  [NR];
    logic [31:0]   exp_q [$];
    logic [NR-1:0] hs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit srcs_empty();
        bit e = 1'b1;
        for (int i = 0; i < NR; i++) begin
            if (src_head[i] < src_len[i]) e = 1'b0;
        end
        return e;
    endfunction

    task automatic load(input int id, input int n, input logic [DW-1:0] base);
        for (int b = 0; b < n; b++) begin
            src_data[id][src_len[id]] = DW'(int'(base) + b);
            src_len[id]++;
        end
    endtask

    task automatic expect_beat(input int id, input logic [DW-1:0] data);
        exp_q.push_back({14'b0, 2'(id), data});
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (src_head[i] < src_len[i]) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = src_data[i][src_head[i]];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = '0;
            end
        end
    endtask

    // One clock: drive sources, record the handshake, advance, then check the write port.
    task automatic cycle();
        logic [31:0] e;
        drive();
        #1;
        hs = req_valid & req_ready;
        chk("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
        @(posedge clk);
        for (int i = 0; i < NR; i++) begin
            if (hs[i]) src_head[i]++;
        end
        @(negedge clk);
        if (fifo_wr_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", {14'b0, grant_id, fifo_data_in}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_beat", {14'b0, grant_id, fifo_data_in}, e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((!srcs_empty() || exp_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        chk("drained", 32'(srcs_empty() && exp_q.size() == 0), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NR; i++) begin
            src_head[i] = 0;
            src_len[i]  = 0;
        end
        rst             = 1'b1;
        fifo_full       = 1'b0;
        fifo_almostfull = 1'b0;
        fifo_overflow   = 1'b0;
        req_valid       = '0;
        req_data        = '0;
        hs              = '0;

        // Reset, then idle with no requests
        idle(2);
        rst = 1'b0;
        idle(5);
        chk("rst_wr_en",    32'(fifo_wr_en),   32'd0);
        chk("rst_data_in",  32'(fifo_data_in), 32'd0);
        chk("rst_grant_id", 32'(grant_id),     32'd0);
        chk("rst_busy",     32'(busy),         32'd0);
        chk("rst_ovf",      32'(overflow_err), 32'd0);
        chk("rst_count",    32'(beat_count),   32'd0);
        chk("rst_ready",    32'(req_ready),    32'd0);

        // All four requesters valid: full bursts in round-robin order
        for (int i = 0; i < NR; i++) load(i, 4, DW'(16'h1000 + i * 16'h0100));
        for (int i = 0; i < NR; i++) begin
            for (int b = 0; b < 4; b++) expect_beat(i, DW'(16'h1000 + i * 16'h0100 + b));
        end
        drain(60);
        idle(2);
        chk("rr_count16", 32'(beat_count), 32'd16);

        // Lone requester 2 drops valid after two beats
        load(2, 2, 16'h2200);
        expect_beat(2, 16'h2200);
        expect_beat(2, 16'h2201);
        drain(20);
        cycle();
        chk("drop_busy", 32'(busy), 32'd0);
        idle(1);
        // Pointer now at 3: with 3 idle the scan wraps to 0, then 1
        load(0, 1, 16'h3000);
        load(1, 1, 16'h3100);
        expect_beat(0, 16'h3000);
        expect_beat(1, 16'h3100);
        drain(20);
        idle(2);
        load(2, 2, 16'h3200);
        expect_beat(2, 16'h3200);
        expect_beat(2, 16'h3201);
        drain(20);
        idle(2);
        // Pointer at 3 again: 3 is served before 0
        load(0, 1, 16'h3400);
        load(3, 1, 16'h3300);
        expect_beat(3, 16'h3300);
        expect_beat(0, 16'h3400);
        drain(20);
        idle(2);
        chk("count24", 32'(beat_count), 32'd24);

        // Almost-full with a write in flight, then full stall mid-burst
        load(1, 6, 16'h4100);
        load(2, 1, 16'h4200);
        for (int b = 0; b < 4; b++) expect_beat(1, DW'(16'h4100 + b));
        expect_beat(2, 16'h4200);
        expect_beat(1, 16'h4104);
        expect_beat(1, 16'h4105);
        cycle();
        fifo_almostfull = 1'b1;
        cycle();
        chk("af_inflight_block", 32'(hs), 32'd0);
        fifo_almostfull = 1'b0;
        fifo_full       = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("full_no_accept", 32'(hs),   32'd0);
            chk("full_owner",     32'(busy), 32'd1);
        end
        fifo_full = 1'b0;
        drain(40);
        idle(2);
        chk("count31", 32'(beat_count), 32'd31);

        // Reset lands on an accepting edge mid-burst
        load(0, 4, 16'h5000);
        expect_beat(0, 16'h5000);
        expect_beat(0, 16'h5001);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_wr_en", 32'(fifo_wr_en),   32'd0);
        chk("mid_rst_count", 32'(beat_count),   32'd0);
        chk("mid_rst_busy",  32'(busy),         32'd0);
        chk("mid_rst_expq",  32'(exp_q.size()), 32'd0);
        for (int i = 0; i < NR; i++) src_head[i] = src_len[i];
        load(3, 1, 16'h5300);
        load(1, 1, 16'h5100);
        expect_beat(1, 16'h5100);
        expect_beat(3, 16'h5300);
        drain(20);
        idle(2);
        chk("post_rst_count", 32'(beat_count), 32'd2);

        // Sticky overflow flag
        fifo_overflow = 1'b1;
        cycle();
        fifo_overflow = 1'b0;
        chk("ovf_set", 32'(overflow_err), 32'd1);
        idle(3);
        chk("ovf_sticky", 32'(overflow_err), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("ovf_cleared", 32'(overflow_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
